// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//
// Eight requesters share one 8:1 WIDTH-bit select path. One requester is
// chosen per transfer and its word is captured into an output register that
// is handed to a single consumer with a valid/ready handshake.
//
// Build option:
//   MUX_ARB_FIXED_PRIO_EN  defined   -> lowest set req index always wins
//                          undefined -> round-robin from the last grant
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[7:0]   level request, bit i = requester i
//   in0..in7   data word of requester i, sampled only in its grant cycle
//   out_ready  consumer accepts out when high together with out_valid
//   out        registered selected word
//   out_valid  out holds a word not yet accepted
//   sel        index of the requester whose word is in out
//   gnt        one-hot pulse: requester i's word was captured this edge

module mux8_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ROT_RESET = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       sel,
    output logic [7:0]       gnt
);

    // state | meaning
    // EMPTY | output register holds nothing for the consumer
    // FULL  | out/sel hold a captured word awaiting out_ready
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [2:0]       sel_nxt;
    logic [7:0]       gnt_nxt;

    logic [2:0]       winner;
    logic             found;
    logic [2:0]       idx;
    logic [WIDTH-1:0] win_word;
    logic             load;

    // Winner selection. Round-robin searches upward from ptr+1 and wraps; the
    // last candidate examined (ptr itself) lets a lone requester win again.
`ifdef MUX_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        case (winner)
            3'd0:    win_word = in0;
            3'd1:    win_word = in1;
            3'd2:    win_word = in2;
            3'd3:    win_word = in3;
            3'd4:    win_word = in4;
            3'd5:    win_word = in5;
            3'd6:    win_word = in6;
            3'd7:    win_word = in7;
            default: win_word = '0;
        endcase
    end

    // A new word may be captured whenever the register is empty or is being
    // drained this same cycle, which gives back-to-back transfers.
    assign load = (req != 8'd0) && ((state == EMPTY) || out_ready);

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        gnt_nxt   = 8'd0;
        if (load) begin
            state_nxt = FULL;
            out_nxt   = win_word;
            sel_nxt   = winner;
            ptr_nxt   = winner;
            gnt_nxt   = 8'd1 << winner;
        end else if ((state == FULL) && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            out   <= '0;
            sel   <= 3'd0;
            ptr   <= 3'(ROT_RESET);
            gnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [7:0]       req;
    logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [2:0]       sel;
    logic [7:0]       gnt;

    int n_pass  = 0;
    int n_total = 0;

    mux8_rr_arbiter #(.WIDTH(WIDTH), .ROT_RESET(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .in5       (in5),
        .in6       (in6),
        .in7       (in7),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change after a falling edge; outputs are read after the next one
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_default_words();
        in0 = 16'h1000; in1 = 16'h1001; in2 = 16'h1002; in3 = 16'h1003;
        in4 = 16'h1004; in5 = 16'h1005; in6 = 16'h1006; in7 = 16'h1007;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
        load_default_words();
        tick(); tick();
        n_total++; if (out !== 16'h0000) $display("FAIL reset_out got %h exp 0000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d exp 0", sel); else n_pass++;
        n_total++; if (gnt !== 8'h00) $display("FAIL reset_gnt got %h exp 00", gnt); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++; if (sel !== 3'd0) $display("FAIL first_grant_sel got %0d exp 0", sel); else n_pass++;
        n_total++; if (gnt !== 8'h01) $display("FAIL first_grant_gnt got %h exp 01", gnt); else n_pass++;
        n_total++; if (out !== 16'h1000) $display("FAIL first_grant_out got %h exp 1000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL first_grant_valid got %b exp 1", out_valid); else n_pass++;
        req = 8'h00;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL first_drain_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (gnt !== 8'h00) $display("FAIL first_drain_gnt got %h exp 00", gnt); else n_pass++;
    endtask

    task automatic test_single();
        req = 8'h08; in3 = 16'hA5A5; out_ready = 1'b1;
        tick();
        n_total++; if (out !== 16'hA5A5) $display("FAIL single_out got %h exp a5a5", out); else n_pass++;
        n_total++; if (sel !== 3'd3) $display("FAIL single_sel got %0d exp 3", sel); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (gnt !== 8'h08) $display("FAIL single_gnt got %h exp 08", gnt); else n_pass++;
        req = 8'h00; in3 = 16'h1003;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_drop_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (gnt !== 8'h00) $display("FAIL single_drop_gnt got %h exp 00", gnt); else n_pass++;
        n_total++; if (out !== 16'hA5A5) $display("FAIL single_hold_out got %h exp a5a5", out); else n_pass++;
        n_total++; if (sel !== 3'd3) $display("FAIL single_hold_sel got %0d exp 3", sel); else n_pass++;
    endtask

    task automatic test_rr_sweep();
        logic [2:0] exp_sel;
        logic [7:0] exp_gnt;
        rst_n = 1'b0; req = 8'h00; out_ready = 1'b1;
        tick();
        rst_n = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
`ifdef MUX_ARB_FIXED_PRIO_EN
            exp_sel = 3'd0;
`else
            exp_sel = 3'(i % 8);
`endif
            exp_gnt = 8'd1 << exp_sel;
            n_total++; if (sel !== exp_sel) $display("FAIL sweep_sel[%0d] got %0d exp %0d", i, sel, exp_sel); else n_pass++;
            n_total++; if (out !== (16'h1000 + 16'(exp_sel))) $display("FAIL sweep_out[%0d] got %h exp %h", i, out, 16'h1000 + 16'(exp_sel)); else n_pass++;
            n_total++; if (gnt !== exp_gnt) $display("FAIL sweep_gnt[%0d] got %h exp %h", i, gnt, exp_gnt); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL sweep_valid[%0d] got %b exp 1", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        req = 8'h04; out_ready = 1'b1;
        tick();
        n_total++; if (sel !== 3'd2) $display("FAIL bp_load_sel got %0d exp 2", sel); else n_pass++;
        n_total++; if (gnt !== 8'h04) $display("FAIL bp_load_gnt got %h exp 04", gnt); else n_pass++;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in2 = 16'hBEE0 + 16'(k);
            req = (k % 2 == 0) ? 8'hFF : 8'h04;
            tick();
            n_total++; if (out !== 16'h1002) $display("FAIL bp_out[%0d] got %h exp 1002", k, out); else n_pass++;
            n_total++; if (sel !== 3'd2) $display("FAIL bp_sel[%0d] got %0d exp 2", k, sel); else n_pass++;
            n_total++; if (gnt !== 8'h00) $display("FAIL bp_gnt[%0d] got %h exp 00", k, gnt); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", k, out_valid); else n_pass++;
        end
        in2 = 16'h1002; out_ready = 1'b1; req = 8'h18;
        tick();
        n_total++; if (sel !== 3'd3) $display("FAIL bp_release_sel got %0d exp 3", sel); else n_pass++;
        n_total++; if (out !== 16'h1003) $display("FAIL bp_release_out got %h exp 1003", out); else n_pass++;
        n_total++; if (gnt !== 8'h08) $display("FAIL bp_release_gnt got %h exp 08", gnt); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_release_valid got %b exp 1", out_valid); else n_pass++;
        req = 8'h00;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        req = 8'h20; out_ready = 1'b1;
        tick();
        n_total++; if (sel !== 3'd5) $display("FAIL mid_sel got %0d exp 5", sel); else n_pass++;
        n_total++; if (out !== 16'h1005) $display("FAIL mid_out got %h exp 1005", out); else n_pass++;
        rst_n = 1'b0; req = 8'h21;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out !== 16'h0000) $display("FAIL mid_rst_out got %h exp 0000", out); else n_pass++;
        n_total++; if (sel !== 3'd0) $display("FAIL mid_rst_sel got %0d exp 0", sel); else n_pass++;
        n_total++; if (gnt !== 8'h00) $display("FAIL mid_rst_gnt got %h exp 00", gnt); else n_pass++;
        rst_n = 1'b1; out_ready = 1'b0;
        tick();
        n_total++; if (sel !== 3'd0) $display("FAIL mid_after_sel got %0d exp 0", sel); else n_pass++;
        n_total++; if (gnt !== 8'h01) $display("FAIL mid_after_gnt got %h exp 01", gnt); else n_pass++;
        n_total++; if (out !== 16'h1000) $display("FAIL mid_after_out got %h exp 1000", out); else n_pass++;
        tick();
        n_total++; if (sel !== 3'd0) $display("FAIL mid_hold_sel got %0d exp 0", sel); else n_pass++;
        n_total++; if (gnt !== 8'h00) $display("FAIL mid_hold_gnt got %h exp 00", gnt); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_hold_valid got %b exp 1", out_valid); else n_pass++;
        out_ready = 1'b1; req = 8'h00;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_drain_valid got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_two_req();
        logic [2:0] exp_seq [4];
        logic [7:0] exp_gnt;
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp_seq[0] = 3'd2; exp_seq[1] = 3'd2; exp_seq[2] = 3'd2; exp_seq[3] = 3'd2;
`else
        exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd2; exp_seq[3] = 3'd3;
`endif
        req = 8'h0C; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_gnt = 8'd1 << exp_seq[i];
            n_total++; if (sel !== exp_seq[i]) $display("FAIL two_req_sel[%0d] got %0d exp %0d", i, sel, exp_seq[i]); else n_pass++;
            n_total++; if (gnt !== exp_gnt) $display("FAIL two_req_gnt[%0d] got %h exp %h", i, gnt, exp_gnt); else n_pass++;
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;
        load_default_words();
        @(negedge clk);
        test_reset();
        test_single();
        test_rr_sweep();
        test_backpressure();
        test_reset_mid();
        test_two_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
